adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 104 ++++++++++
 tb/tb_adder_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared external adder with LAT-cycle latency.
// Define ADDER_ARBITER_STATS_EN to build the saturating per-requester grant counters.
module adder_arbiter #(
    parameter int N   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N:0]   add_sum,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [N:0]   resp_sum,
    input  logic         resp_ready,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    logic [2:0] wait_cnt;
    logic       last_grant;
    logic       grant0;
    logic       grant1;
    logic       accept;

    // On a tie the requester that did not win last time gets the adder.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && !rst && grant0;
        req1_ready = (state == IDLE) && !rst && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            last_grant <= 1'b1;
            add_a      <= '0;
            add_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_a      <= req1_ready ? req1_a : req0_a;
                        add_b      <= req1_ready ? req1_b : req0_b;
                        resp_id    <= req1_ready;
                        last_grant <= req1_ready;
                        wait_cnt   <= 3'(LAT);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // The adder output is settled on the edge where the count has run out.
                    if (wait_cnt == 3'd0) begin
                        resp_sum   <= add_sum;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`else
    assign grant_cnt0 = 16'd0;
    assign grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized plus directed bench for adder_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_adder_arbiter;
    localparam int N   = 32;
    localparam int LAT = 1;
`ifdef ADDER_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [N+1:0] rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic [N-1:0] add_a, add_b;
    logic [N:0]   add_sum = '0;
    logic         resp_valid, resp_id;
    logic [N:0]   resp_sum;
    logic         resp_ready = 1'b1;
    logic [15:0]  grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;
    rsp_t got_q[$];

    always #5 clk = ~clk;

    adder_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
        .resp_ready(resp_ready),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // External adder with one register stage.
    always @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, response due a fixed number of edges later.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_due = 0;
    bit          m_last = 1'b1;
    bit          m_id = 1'b0;
    logic [N-1:0] m_a = '0, m_b = '0;
    logic [N:0]  m_sum = '0;
    logic [15:0] m_cnt0 = '0, m_cnt1 = '0;

    function automatic bit exp_ready(input bit r);
        bit win;
        if (rst || m_busy) return 1'b0;
        if (req0_valid && req1_valid) win = !m_last;
        else if (req1_valid) win = 1'b1;
        else if (req0_valid) win = 1'b0;
        else return 1'b0;
        return win == r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_last = 1; m_id = 0; m_a = '0; m_b = '0; m_sum = '0;
            m_cnt0 = '0; m_cnt1 = '0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_id   = (req0_valid && req1_valid) ? !m_last : req1_valid;
                m_a    = m_id ? req1_a : req0_a;
                m_b    = m_id ? req1_b : req0_b;
                m_sum  = {1'b0, m_a} + {1'b0, m_b};
                m_last = m_id;
                m_busy = 1;
                m_due  = cyc + LAT + 2;
                if (m_id) begin if (m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 1; end
                else begin if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 1; end
            end
        end else if (cyc >= m_due && resp_ready) begin
            m_busy = 0;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : compare
        bit ev;
        #1;
        ev = m_busy && (cyc >= m_due);
        chk("req0_ready", req0_ready, exp_ready(1'b0));
        chk("req1_ready", req1_ready, exp_ready(1'b1));
        chk("resp_valid", resp_valid, ev);
        if (ev) begin
            chk("resp_id", resp_id, m_id);
            chk("resp_sum", resp_sum, m_sum);
        end
        chk("add_a", add_a, m_a);
        chk("add_b", add_b, m_b);
        chk("grant_cnt0", grant_cnt0, STATS ? m_cnt0 : 16'd0);
        chk("grant_cnt1", grant_cnt1, STATS ? m_cnt1 : 16'd0);
        if (resp_valid && resp_ready) got_q.push_back({resp_id, resp_sum});
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drive(input bit id, input logic [N-1:0] a, input logic [N-1:0] b);
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else begin req0_valid = 1; req0_a = a; req0_b = b; end
    endtask

    // Called at a negedge with the request already driven; returns #1 into the accept cycle.
    task automatic wait_accept(input bit id);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) return;
            @(negedge clk);
        end
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // Returns #1 into the first cycle with resp_valid high; lat counts edges after acceptance.
    task automatic wait_resp(output rsp_t r, output int lat);
        r = '0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (resp_valid) begin r = {resp_id, resp_sum}; return; end
            @(negedge clk);
            lat++;
        end
        chk("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic single(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                          output rsp_t r, output int lat);
        @(negedge clk);
        resp_ready = 1;
        drive(id, a, b);
        wait_accept(id);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        wait_resp(r, lat);
    endtask

    initial begin
        rsp_t r;
        int   lat;

        // Reset with both requesters pushing: no ready may leak through.
        req0_valid = 1; req1_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; rst = 0;
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_sum", resp_sum, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_add_a", add_a, 0);

        // Single req0 transaction.
        single(1'b0, 32'd1000, 32'd1000, r, lat);
        chk("t1_latency", lat, LAT + 1);
        chk("t1_resp", r, {1'b0, 33'd2000});

        // Both held after reset: grants alternate starting with requester 0.
        do_reset();
        got_q.delete();
        drive(1'b0, 32'd3000, 32'd3000);
        drive(1'b1, 32'd4000, 32'd4000);
        for (int k = 0; k < 60 && got_q.size() < 3; k++) begin @(negedge clk); #2; end
        chk("t2_count", got_q.size() >= 3, 1);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (8) @(negedge clk);
        if (got_q.size() >= 3) begin
            chk("t2_resp0", got_q[0], {1'b0, 33'd6000});
            chk("t2_resp1", got_q[1], {1'b1, 33'd8000});
            chk("t2_resp2", got_q[2], {1'b0, 33'd6000});
        end

        // Carry out of the top bit.
        single(1'b1, 32'hFFFF_FFFF, 32'h1, r, lat);
        chk("t3_resp", r, {1'b1, 33'h1_0000_0000});

        // Consumer stalls with another requester waiting.
        @(negedge clk);
        resp_ready = 0;
        drive(1'b0, 32'd7, 32'd9);
        wait_accept(1'b0);
        @(negedge clk);
        req0_valid = 0;
        drive(1'b1, 32'd11, 32'd12);
        wait_resp(r, lat);
        chk("t4_resp", r, {1'b0, 33'd16});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("t4_hold_valid", resp_valid, 1);
            chk("t4_hold_sum", resp_sum, 33'd16);
            chk("t4_hold_ready0", req0_ready, 0);
            chk("t4_hold_ready1", req1_ready, 0);
        end
        @(negedge clk);
        resp_ready = 1;
        @(negedge clk);
        #1;
        chk("t4_idle_valid", resp_valid, 0);
        chk("t4_idle_ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 0;
        repeat (6) @(negedge clk);

        // Reset while waiting on the adder: the operation vanishes.
        @(negedge clk);
        drive(1'b0, 32'd1, 32'd2);
        wait_accept(1'b0);
        @(negedge clk);
        req0_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t5_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        single(1'b0, 32'd5000, 32'd5000, r, lat);
        chk("t5_resp", r, {1'b0, 33'd10000});

        // Grant statistics.
        do_reset();
        for (int k = 0; k < 3; k++) single(1'b0, 32'(k), 32'd1, r, lat);
        for (int k = 0; k < 2; k++) single(1'b1, 32'(k), 32'd2, r, lat);
        @(negedge clk);
        #1;
        chk("t6_cnt0", grant_cnt0, STATS ? 16'd3 : 16'd0);
        chk("t6_cnt1", grant_cnt1, STATS ? 16'd2 : 16'd0);

        // Random traffic, stalls and occasional reset.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid) begin
                req0_a = $urandom; req0_b = $urandom;
                req0_valid = $urandom_range(0, 1);
            end else if ($urandom_range(0, 2) == 0) begin
                req0_valid = 0;
            end
            if (!req1_valid) begin
                req1_a = $urandom; req1_b = $urandom;
                req1_valid = $urandom_range(0, 1);
            end else if ($urandom_range(0, 2) == 0) begin
                req1_valid = 0;
            end
        end
        @(negedge clk);
        rst = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
